// File: rtl/bcd_pkg.sv
// Shared constants and FSM state encoding for the binary-to-BCD digit driver.
package bcd_pkg;

    localparam int          NUM_DIGITS = 6;
    localparam logic [23:0] BCD_MAX    = 24'h999999;
    localparam logic [31:0] BIN_MAX    = 32'd999999;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble nibble corrector: nibbles of 5 or more get 3 added before the shift.
module bcd_add3 (
    input  logic [3:0] in_i,
    output logic [3:0] out_o
);

    assign out_o = (in_i >= 4'd5) ? in_i + 4'd3 : in_i;

endmodule

// File: rtl/bcd_digit_driver.sv
// Sequential binary-to-BCD converter feeding six seven-segment decoders.
// Optional raw-hex bypass enabled by defining BCD_DIGIT_DRIVER_HEX_MODE_EN.
module bcd_digit_driver
    import bcd_pkg::*;
#(
    parameter int WIDTH = 20
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] value,
    input  logic             value_valid,
`ifdef BCD_DIGIT_DRIVER_HEX_MODE_EN
    input  logic             hex_mode,
`endif
    output logic [23:0]      digits,
    output logic             busy,
    output logic             done,
    output logic             overflow,
    output logic [1:0]       state_dbg_o
);

    localparam int                CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0]  CNT_INIT = CNT_W'(WIDTH);

    logic hex_in;
`ifdef BCD_DIGIT_DRIVER_HEX_MODE_EN
    assign hex_in = hex_mode;
`else
    assign hex_in = 1'b0;
`endif

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   sr_q, sr_d;
    logic [23:0]        acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_q, ovf_d;
    logic               hex_q, hex_d;
    logic               pend_valid_q, pend_valid_d;
    logic [WIDTH-1:0]   pend_value_q, pend_value_d;
    logic               pend_hex_q, pend_hex_d;
    logic [23:0]        digits_q, digits_d;
    logic               overflow_q, overflow_d;
    logic               done_q, done_d;

    logic               start;
    logic [WIDTH-1:0]   start_value;
    logic               start_hex;
    logic [23:0]        acc_adj;

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_add3
        bcd_add3 u_add3 (
            .in_i  (acc_q[4*g +: 4]),
            .out_o (acc_adj[4*g +: 4])
        );
    end

    always_comb begin
        state_d      = state_q;
        sr_d         = sr_q;
        acc_d        = acc_q;
        cnt_d        = cnt_q;
        ovf_d        = ovf_q;
        hex_d        = hex_q;
        pend_valid_d = pend_valid_q;
        pend_value_d = pend_value_q;
        pend_hex_d   = pend_hex_q;
        digits_d     = digits_q;
        overflow_d   = overflow_q;
        done_d       = 1'b0;
        start        = 1'b0;
        start_value  = value;
        start_hex    = hex_in;

        case (state_q)
            IDLE: begin
                start = value_valid;
            end
            SHIFT: begin
                acc_d = (acc_adj << 1) | {23'd0, sr_q[WIDTH-1]};
                sr_d  = sr_q << 1;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = DONE;
                end
                if (value_valid) begin
                    pend_valid_d = 1'b1;
                    pend_value_d = value;
                    pend_hex_d   = hex_in;
                end
            end
            DONE: begin
                if (hex_q) begin
                    digits_d   = 24'(sr_q);
                    overflow_d = 1'b0;
                end else begin
                    digits_d   = ovf_q ? BCD_MAX : acc_q;
                    overflow_d = ovf_q;
                end
                done_d       = 1'b1;
                state_d      = IDLE;
                pend_valid_d = 1'b0;
                // A strobe landing in this cycle beats the older pending entry.
                if (value_valid) begin
                    start = 1'b1;
                end else if (pend_valid_q) begin
                    start       = 1'b1;
                    start_value = pend_value_q;
                    start_hex   = pend_hex_q;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (start) begin
            sr_d    = start_value;
            acc_d   = 24'd0;
            cnt_d   = CNT_INIT;
            hex_d   = start_hex;
            ovf_d   = !start_hex && (32'(start_value) > BIN_MAX);
            state_d = start_hex ? DONE : SHIFT;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            sr_q         <= '0;
            acc_q        <= '0;
            cnt_q        <= '0;
            ovf_q        <= 1'b0;
            hex_q        <= 1'b0;
            pend_valid_q <= 1'b0;
            pend_value_q <= '0;
            pend_hex_q   <= 1'b0;
            digits_q     <= '0;
            overflow_q   <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            sr_q         <= sr_d;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            ovf_q        <= ovf_d;
            hex_q        <= hex_d;
            pend_valid_q <= pend_valid_d;
            pend_value_q <= pend_value_d;
            pend_hex_q   <= pend_hex_d;
            digits_q     <= digits_d;
            overflow_q   <= overflow_d;
            done_q       <= done_d;
        end
    end

    assign digits      = digits_q;
    assign overflow    = overflow_q;
    assign done        = done_q;
    assign busy        = (state_q != IDLE);
    assign state_dbg_o = state_q;

endmodule

// File: tb/tb_bcd_digit_driver.sv
// Scoreboard bench for bcd_digit_driver: expected display words are queued at strobe time
// and compared against every done pulse, together with the edge on which it arrives.
module tb_bcd_digit_driver;

    localparam int W = 20;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [W-1:0]  value = '0;
    logic          value_valid = 1'b0;
`ifdef BCD_DIGIT_DRIVER_HEX_MODE_EN
    logic          hex_mode = 1'b0;
`endif
    logic [23:0]   digits;
    logic          busy;
    logic          done;
    logic          overflow;
    logic [1:0]    state_dbg;

    bcd_digit_driver #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .value       (value),
        .value_valid (value_valid),
`ifdef BCD_DIGIT_DRIVER_HEX_MODE_EN
        .hex_mode    (hex_mode),
`endif
        .digits      (digits),
        .busy        (busy),
        .done        (done),
        .overflow    (overflow),
        .state_dbg_o (state_dbg)
    );

    // clock / edge counter
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // checking
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got=%h expected=%h (edge %0d)", tag, got, exp, cyc);
    endtask

    // reference model: decimal digits by division, saturating above 999999
    function automatic logic [24:0] model(input logic [W-1:0] v, input logic hx);
        logic [24:0] r;
        int unsigned x;
        r = '0;
        x = 32'(v);
        if (hx) begin
            r = {1'b0, 24'(v)};
        end else if (x > 999999) begin
            r = {1'b1, 24'h999999};
        end else begin
            for (int i = 0; i < 6; i++) begin
                r[4*i +: 4] = 4'(x % 10);
                x = x / 10;
            end
        end
        return r;
    endfunction

    // scoreboard
    logic [24:0] exp_q[$];
    int          exp_edge_q[$];

    always @(negedge clk) begin
        if (!reset && done) begin
            if (exp_q.size() == 0) begin
                check_eq("spurious_done", {8'd0, overflow, digits}, 32'h0);
            end else begin
                logic [24:0] e;
                int          ed;
                e  = exp_q.pop_front();
                ed = exp_edge_q.pop_front();
                check_eq("digits", 32'(digits), 32'(e[23:0]));
                check_eq("overflow", 32'(overflow), 32'(e[24]));
                check_eq("done_edge", cyc, ed);
            end
        end
    end

    // drivers
    task automatic drive(input logic [W-1:0] v, input logic hx, input bit expect_it, input int ofs);
        int sample;
        @(negedge clk);
        value       = v;
        value_valid = 1'b1;
`ifdef BCD_DIGIT_DRIVER_HEX_MODE_EN
        hex_mode    = hx;
`endif
        sample = cyc + 1;
        if (expect_it) begin
            exp_q.push_back(model(v, hx));
            exp_edge_q.push_back(sample + ofs);
        end
        @(posedge clk);
        #1;
        value_valid = 1'b0;
`ifdef BCD_DIGIT_DRIVER_HEX_MODE_EN
        hex_mode    = 1'b0;
`endif
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && exp_q.size() > 0; i++) @(negedge clk);
        @(negedge clk);
        if (exp_q.size() > 0) begin
            check_eq("drain_timeout", exp_q.size(), 0);
            exp_q.delete();
            exp_edge_q.delete();
        end
    endtask

    initial begin
        int busy_cycles;
        logic [W-1:0] rv;

        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_eq("rst_digits", 32'(digits), 0);
        check_eq("rst_busy", 32'(busy), 0);
        check_eq("rst_done", 32'(done), 0);
        check_eq("rst_overflow", 32'(overflow), 0);

        // zero, with busy duration
        drive(0, 1'b0, 1'b1, 21);
        busy_cycles = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (busy) busy_cycles++;
        end
        check_eq("busy_cycles", busy_cycles, 21);
        drain();

        // ordinary value, then hold
        drive(20'd123456, 1'b0, 1'b1, 21);
        drain();
        idle(5);
        check_eq("hold_digits", 32'(digits), 32'h123456);
        check_eq("hold_done_low", 32'(done), 0);

        // boundary of the display range
        drive(20'd999999, 1'b0, 1'b1, 21);
        drain();
        drive(20'hF4240, 1'b0, 1'b1, 21);
        drain();
        check_eq("ovf_held", 32'(overflow), 1);

        // pending slot: 7 overwritten by 815, 815 starts straight from DONE
        drive(20'd42, 1'b0, 1'b1, 21);
        idle(4);
        drive(20'd7, 1'b0, 1'b0, 0);
        idle(4);
        drive(20'd815, 1'b0, 1'b1, 32);
        drain();

        // reset aborts a conversion in flight
        drive(20'd500000, 1'b0, 1'b0, 0);
        idle(7);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check_eq("abort_digits", 32'(digits), 0);
        check_eq("abort_busy", 32'(busy), 0);
        check_eq("abort_overflow", 32'(overflow), 0);
        idle(30);
        drive(20'd31, 1'b0, 1'b1, 21);
        drain();

        // random values, including the upper end of the input range
        for (int i = 0; i < 8; i++) begin
            rv = W'($urandom_range(0, (1 << W) - 1));
            drive(rv, 1'b0, 1'b1, 21);
            drain();
        end
        drive({W{1'b1}}, 1'b0, 1'b1, 21);
        drain();

`ifdef BCD_DIGIT_DRIVER_HEX_MODE_EN
        drive(20'hABCDE, 1'b1, 1'b1, 1);
        drain();
        drive(20'd255, 1'b0, 1'b1, 21);
        drain();
`endif

        idle(3);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/bcd_digit_driver.md
Name: bcd_digit_driver

Overview:
- Upstream feeder for the six seven-segment decoders on HEX0..HEX5.
- Accepts a binary measurement value, e.g. an edge-pixel count or a frame counter, on a one-cycle valid strobe.
- Converts it to six BCD nibbles with a sequential shift-add-3 (double-dabble) engine and holds the result stable for the decoders.
- Each digit output drives one decoder's 4-bit input directly.

Parameters:
- WIDTH, 20, bit width of the binary input value. Legal range 4..24.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- value  in  WIDTH  binary value to display.
- value_valid  in  1  one-cycle strobe; value is sampled on the same edge.
- digits  out  24  packed BCD. [3:0]=ones (HEX0) ... [23:20]=hundred-thousands (HEX5).
- busy  out  1  high while a conversion is in flight (state != IDLE).
- done  out  1  one-cycle pulse in the cycle digits update.
- overflow  out  1  high when the currently displayed value is > 999999.

Behaviour:
- Reset (synchronous, active-high):
  - digits=0, busy=0, done=0, overflow=0.
  - Pending slot cleared, state=IDLE.
  - A reset asserted mid-conversion aborts it; nothing from that conversion reaches the outputs.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - If value_valid is high at edge N: load shift register with value, clear the BCD accumulator, set shift count to WIDTH.
  - Register the overflow compare (value > 999999), then go to SHIFT.
- SHIFT (one bit per cycle):
  - Add 3 to every accumulator nibble >= 5, then shift {accumulator, shift register} left by 1.
  - Edges N+1..N+WIDTH perform the shifts; after the WIDTH-th shift, go to DONE.
- DONE (cycle after the last shift):
  - On edge N+WIDTH+1, register digits = accumulator, or 0x999999 if the overflow flag is set.
  - Update overflow; done=1 for exactly this cycle.
  - Latency from sample edge to digits valid = WIDTH+1 edges (21 at default).
- Next state from DONE:
  - SHIFT, loading the pending value, if the pending slot is valid. This gives back-to-back operation with no IDLE cycle.
  - Otherwise IDLE.
- Pending slot (one entry):
  - value_valid while in SHIFT or DONE writes value into the slot and sets its valid flag.
  - A later strobe overwrites it; last value wins, earlier pending values are dropped.
  - A strobe in the DONE cycle has priority over an existing pending entry and is the one started next.
- digits, overflow:
  - Change only on a done cycle; stable otherwise, so the decoders see no intermediate values.
- Width rules:
  - Accumulator is 24 bits and is never truncated.
  - For WIDTH < 20 overflow is constant 0.
  - For WIDTH > 20, values >= 10^6 saturate the display to 999999.

Optional Feature:
- Macro: BCD_DIGIT_DRIVER_HEX_MODE_EN.
- With the macro:
  - Extra input port hex_mode (1 bit), sampled with value_valid and stored alongside pending entries.
  - When it is sampled high, the conversion is bypassed: IDLE -> DONE directly.
  - digits = value zero-extended to 24 bits, overflow=0, latency 1 edge. The seven-segment decoders then show raw hex A-F.
- Without the macro: no hex_mode port; all requests are BCD conversions.

Decomposition:
- Shared package bcd_pkg:
  - NUM_DIGITS=6.
  - BCD_MAX=24'h999999 and BIN_MAX=999999.
  - State typedef {IDLE, SHIFT, DONE}.
- One natural sub-module: bcd_add3, a combinational 4-bit nibble corrector (in>=5 ? in+3 : in). It is instantiated NUM_DIGITS times inside the shift stage.

Test Plan:
- Reset, then value=0 strobed -> done at edge +21; digits=0x000000, overflow=0; busy high for exactly 21 cycles.
- value=123456 -> digits=0x123456 after 21 edges; digits held unchanged until the next done.
- value=999999, then value=1000000 (20'hF4240) -> 0x999999/overflow=0, then 0x999999/overflow=1.
- Start 42, strobe 7 at +5 and 815 at +10 -> done with 0x000042, then next cycle enters SHIFT; done with 0x000815 21 edges later; 7 never displayed.
- Start 500000, assert reset at +8 for 1 cycle -> digits=0, busy=0, no done pulse; following strobe of 31 -> 0x000031 normally.
- (Macro defined) hex_mode=1, value=20'hABCDE -> done on next edge, digits=0x0ABCDE; then hex_mode=0, value=255 -> 0x000255.
